riscv_lsu: RTL

Parametrised load/store unit between the RISC-V core's execute stage and a data bus with ready/valid handshakes and variable latency. It replaces the core's direct single-cycle data-memory port: it generates byte strobes and sign/zero-extends loads for all RV32/RV64 widths. It detects misaligned, illegal-width and timed-out accesses, and drives `stall` to freeze the core while an access is outstanding. While `rst` is high it passes the external program/data loader straight through to the bus.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/lsu_align.sv | 78 +++++++
 rtl/riscv_lsu.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// fault causes and the byte-strobe helper.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_TIMEOUT  = 2'b10,
        CAUSE_ILLEGAL  = 2'b11
    } fault_cause_t;

    // Unshifted byte mask for the access size encoded in funct3[1:0].
    function automatic logic [7:0] strb_mask(input logic [2:0] funct3);
        logic [7:0] m;
        case (funct3[1:0])
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: strobes, store replication, load extraction and
// extension, plus width/alignment legality checks.
module lsu_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]                   funct3,
    input  logic                         write,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [XLEN-1:0]              store_data,
    input  logic [XLEN-1:0]              rdata,
    output logic [XLEN/8-1:0]            wstrb,
    output logic [XLEN-1:0]              wdata,
    output logic [XLEN-1:0]              ld_ext,
    output logic                         misaligned,
    output logic                         illegal
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    logic [7:0]      mask8;
    logic [2:0]      span;
    logic [XLEN-1:0] shifted;
    int unsigned     ext_w;
    logic            fill;

    always_comb begin
        mask8 = strb_mask(funct3);
        wstrb = mask8[NB-1:0] << offset;

        case (funct3[1:0])
            2'd0:    span = 3'd0;
            2'd1:    span = 3'd1;
            2'd2:    span = 3'd3;
            default: span = 3'd7;
        endcase
        misaligned = |(offset & span[OFF_W-1:0]);

        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_D:             illegal = (XLEN != 64);
            F3_BU, F3_HU:     illegal = write;
            F3_WU:            illegal = write || (XLEN != 64);
            default:          illegal = 1'b1;
        endcase

        case (funct3[1:0])
            2'd0:    wdata = {NB{store_data[7:0]}};
            2'd1:    wdata = {(NB/2){store_data[15:0]}};
            2'd2:    wdata = {(NB/4){store_data[31:0]}};
            default: wdata = store_data;
        endcase
    end

    // Move the addressed lane to bit 0, then overwrite everything above the
    // access width with the sign bit or zero.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        ext_w   = XLEN;
        fill    = 1'b0;
        case (funct3)
            F3_B:    begin ext_w = 8;  fill = shifted[7];  end
            F3_H:    begin ext_w = 16; fill = shifted[15]; end
            F3_W:    begin ext_w = 32; fill = shifted[31]; end
            F3_BU:   ext_w = 8;
            F3_HU:   ext_w = 16;
            F3_WU:   ext_w = 32;
            default: ext_w = XLEN;
        endcase
        ld_ext = shifted;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i >= ext_w) ld_ext[i] = fill;
        end
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: request FSM with bus timeout, load result register and
// the reset-time loader pass-through onto the data bus.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic [XLEN-1:0]      ld_data,
    output logic                 done,
    output logic                 stall,
    output logic                 fault,
    output logic [1:0]           fault_cause,
    input  logic                 ext_we,
    input  logic [ADDR_W-1:0]    ext_addr,
    input  logic [XLEN-1:0]      ext_wdata,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 bus_write,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic [XLEN/8-1:0]    bus_wstrb,
    output logic [XLEN-1:0]      bus_wdata,
    input  logic [XLEN-1:0]      bus_rdata,
    input  logic                 bus_rvalid
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t   state_q, state_d;
    fault_cause_t cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q;

    logic [OFF_W-1:0] offset;
    logic [NB-1:0]    al_wstrb;
    logic [XLEN-1:0]  al_wdata;
    logic [XLEN-1:0]  al_ld;
    logic             al_mis;
    logic             al_ill;

    assign offset = req_addr[OFF_W-1:0];

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (req_funct3),
        .write      (req_write),
        .offset     (offset),
        .store_data (req_wdata),
        .rdata      (bus_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .ld_ext     (al_ld),
        .misaligned (al_mis),
        .illegal    (al_ill)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                cause_d = CAUSE_NONE;
                if (req_valid) begin
                    if (al_ill) begin
                        state_d = ST_DONE;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (al_mis) begin
                        state_d = ST_DONE;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus_ready) begin
                    state_d = req_write ? ST_DONE : ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (bus_rvalid) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The counter restarts on every state change, which covers both the
    // IDLE->REQ and REQ->RESP entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            cnt_q   <= '0;
            ld_data <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == ST_REQ || state_q == ST_RESP) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ST_RESP && bus_rvalid) begin
                ld_data <= al_ld;
            end
        end
    end

    assign done        = (state_q == ST_DONE) && !rst;
    assign fault       = done && (cause_q != CAUSE_NONE);
    assign fault_cause = done ? cause_q : CAUSE_NONE;
    assign stall       = !rst && ((state_q == ST_IDLE && req_valid) ||
                                  state_q == ST_REQ || state_q == ST_RESP);

    always_comb begin
        bus_valid = 1'b0;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_wstrb = '0;
        bus_wdata = '0;
        if (rst) begin
            bus_valid = ext_we;
            bus_write = 1'b1;
            bus_addr  = ext_addr;
            bus_wstrb = '1;
            bus_wdata = ext_wdata;
        end else if (state_q == ST_REQ) begin
            bus_valid = 1'b1;
            bus_write = req_write;
            bus_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_wstrb = al_wstrb;
            bus_wdata = al_wdata;
        end
    end

endmodule
